// File: rtl/neuron.sv
// Single time-multiplexed neuron: serial MAC over N_INPUTS terms followed by a
// piecewise-linear sigmoid producing an unsigned Q0.OUTPUT_WIDTH fraction.
module neuron #(
  parameter int N_INPUTS            = 5,
  parameter int INPUT_WIDTH         = 9,
  parameter int WEIGHT_WIDTH        = 17,
  parameter int OUTPUT_WIDTH        = 10,
  parameter int SIGNIFICANT         = 16,
  parameter int FUNCTION_RANGE_HIGH = 8,
  parameter int FUNCTION_RANGE_LOW  = -8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [N_INPUTS*INPUT_WIDTH-1:0]    inputs,
  input  logic [N_INPUTS*WEIGHT_WIDTH-1:0]   weights,
  output logic [OUTPUT_WIDTH-1:0]            out_value,
  output logic                               out_valid
);

  localparam int PROD_W    = INPUT_WIDTH + WEIGHT_WIDTH;
  localparam int ACC_W     = PROD_W + $clog2(N_INPUTS);
  localparam int IDX_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int ONE       = 1 << SIGNIFICANT;
  localparam int OUT_SHIFT = SIGNIFICANT - OUTPUT_WIDTH;

  localparam logic signed [ACC_W-1:0] X_HI = ACC_W'(FUNCTION_RANGE_HIGH * ONE);
  localparam logic signed [ACC_W-1:0] X_LO = ACC_W'(FUNCTION_RANGE_LOW * ONE);

  // Segment breakpoints (5.0, 2.375, 1.0) and offsets (0.84375, 0.625, 0.5)
  localparam logic [ACC_W-1:0] A_SAT     = ACC_W'(5 * ONE);
  localparam logic [ACC_W-1:0] A_MID     = ACC_W'((19 * ONE) / 8);
  localparam logic [ACC_W-1:0] A_ONE     = ACC_W'(ONE);
  localparam logic [ACC_W-1:0] Y_OFF_HI  = ACC_W'((27 * ONE) / 32);
  localparam logic [ACC_W-1:0] Y_OFF_MID = ACC_W'((5 * ONE) / 8);
  localparam logic [ACC_W-1:0] Y_OFF_LOW = ACC_W'(ONE / 2);
  localparam logic [ACC_W-1:0] OUT_MAX   = ACC_W'((1 << OUTPUT_WIDTH) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {IDLE, MAC, ACT} state_t;

  state_t                         state;
  logic signed [INPUT_WIDTH-1:0]  in_mem [N_INPUTS];
  logic signed [WEIGHT_WIDTH-1:0] wt_mem [N_INPUTS];
  logic [IDX_W-1:0]               idx;
  logic signed [ACC_W-1:0]        acc;

  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        acc_next;
  logic signed [ACC_W-1:0]        x_clamp;
  logic                           x_neg;
  logic [ACC_W-1:0]               mag;
  logic [ACC_W-1:0]               y_abs;
  logic [ACC_W-1:0]               y_final;
  logic [ACC_W-1:0]               scaled;
  logic [OUTPUT_WIDTH-1:0]        act_value;

  // Shared multiplier: one term of the dot product per cycle
  always_comb begin
    prod     = PROD_W'(in_mem[idx]) * PROD_W'(wt_mem[idx]);
    acc_next = acc + ACC_W'(prod);
  end

  // Piecewise-linear sigmoid evaluated on the magnitude, mirrored for x < 0
  always_comb begin
    if (acc > X_HI)
      x_clamp = X_HI;
    else if (acc < X_LO)
      x_clamp = X_LO;
    else
      x_clamp = acc;

    x_neg = x_clamp[ACC_W-1];
    mag   = x_neg ? $unsigned(-x_clamp) : $unsigned(x_clamp);

    if (mag >= A_SAT)
      y_abs = A_ONE;
    else if (mag >= A_MID)
      y_abs = (mag >> 5) + Y_OFF_HI;
    else if (mag >= A_ONE)
      y_abs = (mag >> 3) + Y_OFF_MID;
    else
      y_abs = (mag >> 2) + Y_OFF_LOW;

    y_final   = x_neg ? (A_ONE - y_abs) : y_abs;
    scaled    = y_final >> OUT_SHIFT;
    act_value = (scaled > OUT_MAX) ? '1 : scaled[OUTPUT_WIDTH-1:0];
  end

  // Control FSM with registered result and one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      out_value <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
              in_mem[i] <= inputs[i*INPUT_WIDTH +: INPUT_WIDTH];
              wt_mem[i] <= weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (idx == IDX_LAST)
            state <= ACT;
          else
            idx <= idx + IDX_W'(1);
        end
        ACT: begin
          out_value <= act_value;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron.sv
// Self-checking bench for neuron: directed vector table, hand-written
// multi-cycle sequences and randomized transactions against an arithmetic model.
module tb_neuron;

  localparam int N  = 5;
  localparam int IW = 9;
  localparam int WW = 17;
  localparam int OW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N*IW-1:0] inputs;
  logic [N*WW-1:0] weights;
  logic [OW-1:0]   out_value;
  logic            out_valid;

  int total  = 0;
  int bad    = 0;
  int pulses = 0;

  typedef struct {
    string name;
    int    in_v[N];
    int    w_v[N];
    int    exp_out;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  neuron #(
    .N_INPUTS(N),
    .INPUT_WIDTH(IW),
    .WEIGHT_WIDTH(WW),
    .OUTPUT_WIDTH(OW),
    .SIGNIFICANT(16),
    .FUNCTION_RANGE_HIGH(8),
    .FUNCTION_RANGE_LOW(-8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .inputs(inputs),
    .weights(weights),
    .out_value(out_value),
    .out_valid(out_valid)
  );

  // Count every high cycle of out_valid
  always @(negedge clk) if (out_valid === 1'b1) pulses++;

  // Reference: exact dot product, then the sigmoid rules in real-unit arithmetic
  function automatic int model(input int in_v[N], input int w_v[N]);
    longint acc, x, a, y;
    acc = 0;
    for (int i = 0; i < N; i++) acc += longint'(in_v[i]) * longint'(w_v[i]);
    x = acc;
    if (x > 8 * 65536) x = 8 * 65536;
    if (x < -8 * 65536) x = -8 * 65536;
    a = (x < 0) ? -x : x;
    if (a >= 5 * 65536)      y = 65536;
    else if (a >= 155648)    y = a / 32 + 55296;
    else if (a >= 65536)     y = a / 8 + 40960;
    else                     y = a / 4 + 32768;
    if (x < 0) y = 65536 - y;
    y = y / 64;
    if (y > 1023) y = 1023;
    return int'(y);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int in_v[N], input int w_v[N]);
    for (int i = 0; i < N; i++) begin
      inputs[i*IW +: IW]  = IW'(in_v[i]);
      weights[i*WW +: WW] = WW'(w_v[i]);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      inputs[i*IW +: IW]  = IW'($urandom);
      weights[i*WW +: WW] = WW'($urandom);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid; lat counts edges after the start edge
  task automatic run_txn(input int in_v[N], input int w_v[N], input bit back2back,
                         output int val, output int lat);
    if (!back2back) @(negedge clk);
    drive(in_v, w_v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    lat = 0;
    val = -1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) begin
        val = int'(out_value);
        break;
      end
    end
  endtask

  initial begin
    int val, lat, p0, exp_v, saved;
    int rin[N], rw[N];

    vecs[0] = '{"near_zero_neg", '{-40, 43, 103, 7, -150}, '{560, -40, -8, 80, -160}, 510};
    vecs[1] = '{"small_pos", '{5, 20, -50, 1, 200}, '{1200, 320, 160, 2400, -24}, 519};
    vecs[2] = '{"pos_sat", '{200, 20, -50, 1, 200}, '{50000, 320, 160, 2400, -24}, 1023};
    vecs[3] = '{"neg_sat", '{200, 20, -50, 1, 200}, '{-5000, 320, 160, 2400, -24}, 0};
    vecs[4] = '{"mid_seg", '{128, 0, 0, 0, 0}, '{768, 0, 0, 0, 0}, 832};

    rst   = 1'b1;
    start = 1'b0;
    inputs  = '0;
    weights = '0;
    repeat (4) @(negedge clk);
    check("reset_out_value", int'(out_value), 0);
    check("reset_out_valid", int'(out_valid), 0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      p0 = pulses;
      run_txn(vecs[i].in_v, vecs[i].w_v, 1'b0, val, lat);
      check({vecs[i].name, "_latency"}, lat, 6);
      check({vecs[i].name, "_value"}, val, vecs[i].exp_out);
      @(negedge clk);
      check({vecs[i].name, "_pulse_end"}, int'(out_valid), 0);
      repeat (3) @(negedge clk);
      #1;
      check({vecs[i].name, "_pulse_count"}, pulses - p0, 1);
      check({vecs[i].name, "_hold"}, int'(out_value), vecs[i].exp_out);
    end

    // Busy-ignore: second start two cycles after the first is dropped
    p0 = pulses;
    @(negedge clk);
    drive(vecs[4].in_v, vecs[4].w_v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    drive(vecs[0].in_v, vecs[0].w_v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    val = -1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) begin
        val = int'(out_value);
        break;
      end
    end
    check("busy_latency", lat, 6);
    check("busy_value", val, 832);
    repeat (12) @(negedge clk);
    #1;
    check("busy_pulse_count", pulses - p0, 1);

    // Back-to-back: start accepted in the same cycle out_valid is high
    run_txn(vecs[0].in_v, vecs[0].w_v, 1'b0, val, lat);
    check("b2b_first_value", val, 510);
    run_txn(vecs[1].in_v, vecs[1].w_v, 1'b1, val, lat);
    check("b2b_second_latency", lat, 6);
    check("b2b_second_value", val, 519);

    // Randomized transactions against the model
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N; i++) begin
        rin[i] = int'($urandom_range(0, 511)) - 256;
        if (k % 2 == 0) rw[i] = int'($urandom_range(0, 4095)) - 2048;
        else if (k % 3 == 0) rw[i] = int'($urandom_range(0, 511)) - 256;
        else rw[i] = int'($urandom_range(0, 131071)) - 65536;
      end
      exp_v = model(rin, rw);
      run_txn(rin, rw, (k > 0) && ($urandom_range(0, 1) == 1), val, lat);
      check($sformatf("rand%0d_latency", k), lat, 6);
      check($sformatf("rand%0d_value", k), val, exp_v);
    end

    // Reset aborts an in-flight request and clears out_value
    run_txn(vecs[1].in_v, vecs[1].w_v, 1'b0, val, lat);
    saved = val;
    check("pre_abort_value", saved, 519);
    @(negedge clk);
    drive(vecs[2].in_v, vecs[2].w_v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    p0 = pulses;
    repeat (2) @(negedge clk);
    check("abort_out_value", int'(out_value), 0);
    check("abort_out_valid", int'(out_valid), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("abort_no_pulse", pulses - p0, 0);

    // Recovery after reset
    run_txn(vecs[4].in_v, vecs[4].w_v, 1'b0, val, lat);
    check("recover_latency", lat, 6);
    check("recover_value", val, 832);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
